// File: rtl/keypad_if.sv
// Keypad-side signal bundle: column sense in, row drive and key event out.
interface keypad_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output key_col, input key_row, key_code, key_valid, key_held);
  modport slave  (input key_col, output key_row, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low row drive, synchronised and
// debounced column sense, one-cycle key event per accepted press.
module keypad_scanner #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic    FPGA_clock,
  input logic    reset,
  keypad_if.slave kp
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] DT       = CW'(DEBOUNCE_TICKS);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  logic [1:0]    state;
  logic [3:0]    col_m, col_s;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [1:0]    row, col, pick;
  logic [CW-1:0] cnt, rel;
  logic [3:0]    act;
  logic          col_hit;
  logic [3:0]    code_q;
  logic          valid_q, held_q;

  assign tick    = (tcnt == DIV_LAST);
  assign act     = ~col_s;
  assign col_hit = act[col];

  // Lowest-index active column wins.
  always_comb begin
    pick = 2'd0;
    if      (act[0]) pick = 2'd0;
    else if (act[1]) pick = 2'd1;
    else if (act[2]) pick = 2'd2;
    else if (act[3]) pick = 2'd3;
  end

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state   <= SCAN;
      col_m   <= 4'hF;
      col_s   <= 4'hF;
      tcnt    <= '0;
      row     <= 2'd0;
      col     <= 2'd0;
      cnt     <= '0;
      rel     <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      col_m   <= kp.key_col;
      col_s   <= col_m;
      tcnt    <= tick ? '0 : tcnt + TW'(1);
      if (tick) begin
        case (state)
          SCAN: begin
            if (act == 4'h0) begin
              row <= row + 2'd1;
            end else begin
              col <= pick;
              if (DEBOUNCE_TICKS == 1) begin
                code_q  <= {row, pick};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt     <= '0;
                state   <= HELD;
              end else begin
                cnt   <= CW'(1);
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (col_hit) begin
              if (cnt + CW'(1) == DT) begin
                code_q  <= {row, col};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                cnt     <= '0;
                state   <= HELD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt   <= '0;
              row   <= row + 2'd1;
              state <= SCAN;
            end
          end
          HELD: begin
            // Row stays put on the releasing tick; scanning resumes next tick.
            if (col_hit) begin
              rel <= '0;
            end else if (rel + CW'(1) == DT) begin
              rel    <= '0;
              held_q <= 1'b0;
              state  <= SCAN;
            end else begin
              rel <= rel + CW'(1);
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kp.key_row   = ~(4'b0001 << row);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple switch-matrix keypad model.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset;
  logic [3:0][3:0] pressed;
  logic [3:0] kcol;
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  logic [3:0] last_code = 4'h0;

  keypad_if kp ();

  keypad_scanner #(.CLK_HZ(100), .SCAN_HZ(10), .DEBOUNCE_TICKS(4)) dut (
    .FPGA_clock (clk),
    .reset      (reset),
    .kp         (kp.slave)
  );

  always #5 clk = ~clk;

  // Pressed switch pulls its column low when its row is driven.
  always_comb begin
    kcol = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.key_row[r] && pressed[r][c]) kcol[c] = 1'b0;
  end
  assign kp.key_col = kcol;

  always @(negedge clk)
    if (kp.key_valid === 1'b1) begin
      vcount++;
      last_code = kp.key_code;
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target);
    int k = 0;
    while (kp.key_row !== target && k < 200) begin step(1); k++; end
    checks++;
    if (kp.key_row !== target) begin
      failures++;
      $display("FAIL wait_row timeout: key_row=%b expected %b", kp.key_row, target);
    end
  endtask

  task automatic align_row1();
    wait_row(4'b1110);
    wait_row(4'b1101);
  endtask

  task automatic wait_held(input logic v);
    int k = 0;
    while (kp.key_held !== v && k < 300) begin step(1); k++; end
    checks++;
    if (kp.key_held !== v) begin
      failures++;
      $display("FAIL wait_held timeout: key_held=%b expected %b", kp.key_held, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (kp.key_row !== 4'b1110) begin failures++; $display("FAIL reset_row: got %b expected 1110", kp.key_row); end
    if (kp.key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h expected 0", kp.key_code); end
    if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", kp.key_valid); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL reset_held: got %b expected 0", kp.key_held); end
    reset = 1'b0;
    step(9);
    checks++;
    if (kp.key_row !== 4'b1110) begin failures++; $display("FAIL walk_9: got %b expected 1110", kp.key_row); end
    step(1);
    checks++;
    if (kp.key_row !== 4'b1101) begin failures++; $display("FAIL walk_10: got %b expected 1101", kp.key_row); end
    step(10);
    checks++;
    if (kp.key_row !== 4'b1011) begin failures++; $display("FAIL walk_20: got %b expected 1011", kp.key_row); end
    step(10);
    checks++;
    if (kp.key_row !== 4'b0111) begin failures++; $display("FAIL walk_30: got %b expected 0111", kp.key_row); end
    step(10);
    checks++;
    if (kp.key_row !== 4'b1110) begin failures++; $display("FAIL walk_40: got %b expected 1110", kp.key_row); end
  endtask

  task automatic test_press_release();
    int base = vcount;
    pressed[1][1] = 1'b1;
    wait_held(1'b1);
    step(2);
    checks += 4;
    if (vcount !== base + 1) begin failures++; $display("FAIL press_count: got %0d expected %0d", vcount - base, 1); end
    if (last_code !== 4'h5) begin failures++; $display("FAIL press_code: got %h expected 5", last_code); end
    if (kp.key_held !== 1'b1) begin failures++; $display("FAIL press_held: got %b expected 1", kp.key_held); end
    if (kp.key_row !== 4'b1101) begin failures++; $display("FAIL press_row_frozen: got %b expected 1101", kp.key_row); end
    pressed[1][1] = 1'b0;
    step(25);
    checks++;
    if (kp.key_held !== 1'b1) begin failures++; $display("FAIL early_release: key_held=%b expected 1", kp.key_held); end
    wait_held(1'b0);
    checks += 2;
    if (kp.key_row !== 4'b1101) begin failures++; $display("FAIL release_row: got %b expected 1101", kp.key_row); end
    if (vcount !== base + 1) begin failures++; $display("FAIL release_count: got %0d expected 1", vcount - base); end
    step(10);
    checks++;
    if (kp.key_row !== 4'b1011) begin failures++; $display("FAIL resume_row: got %b expected 1011", kp.key_row); end
  endtask

  task automatic test_bounce();
    int base = vcount;
    align_row1();
    pressed[1][1] = 1'b1;
    step(10);
    checks++;
    if (kp.key_row !== 4'b1101) begin failures++; $display("FAIL bounce_frozen: got %b expected 1101", kp.key_row); end
    step(10);
    pressed[1][1] = 1'b0;
    step(10);
    checks += 2;
    if (kp.key_row !== 4'b1011) begin failures++; $display("FAIL bounce_drop1_row: got %b expected 1011", kp.key_row); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL bounce_held1: got %b expected 0", kp.key_held); end
    align_row1();
    pressed[1][1] = 1'b1;
    step(10);
    pressed[1][1] = 1'b0;
    step(10);
    checks += 3;
    if (kp.key_row !== 4'b1011) begin failures++; $display("FAIL bounce_drop2_row: got %b expected 1011", kp.key_row); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL bounce_held2: got %b expected 0", kp.key_held); end
    if (vcount !== base) begin failures++; $display("FAIL bounce_count: got %0d expected 0", vcount - base); end
  endtask

  task automatic test_two_keys();
    int base = vcount;
    pressed[2][1] = 1'b1;
    pressed[2][3] = 1'b1;
    wait_held(1'b1);
    step(1);
    checks += 2;
    if (vcount !== base + 1) begin failures++; $display("FAIL twokey_count: got %0d expected 1", vcount - base); end
    if (last_code !== 4'h9) begin failures++; $display("FAIL twokey_code: got %h expected 9", last_code); end
    pressed = '0;
    wait_held(1'b0);
  endtask

  task automatic test_back_to_back();
    int base = vcount;
    pressed[1][1] = 1'b1;
    wait_held(1'b1);
    pressed[1][1] = 1'b0;
    step(20);
    checks++;
    if (kp.key_held !== 1'b1) begin failures++; $display("FAIL b2b_short_release: key_held=%b expected 1", kp.key_held); end
    pressed[1][1] = 1'b1;
    step(30);
    pressed[1][1] = 1'b0;
    wait_held(1'b0);
    step(1);
    checks++;
    if (vcount !== base + 1) begin failures++; $display("FAIL b2b_no_repeat: got %0d expected 1", vcount - base); end
    pressed[1][1] = 1'b1;
    wait_held(1'b1);
    step(1);
    checks += 2;
    if (vcount !== base + 2) begin failures++; $display("FAIL b2b_second: got %0d expected 2", vcount - base); end
    if (last_code !== 4'h5) begin failures++; $display("FAIL b2b_code: got %h expected 5", last_code); end
    pressed[1][1] = 1'b0;
    wait_held(1'b0);
  endtask

  task automatic test_reset_mid();
    int base;
    align_row1();
    pressed[1][1] = 1'b1;
    step(20);
    reset = 1'b1;
    step(1);
    checks += 4;
    if (kp.key_row !== 4'b1110) begin failures++; $display("FAIL rdeb_row: got %b expected 1110", kp.key_row); end
    if (kp.key_code !== 4'h0) begin failures++; $display("FAIL rdeb_code: got %h expected 0", kp.key_code); end
    if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL rdeb_valid: got %b expected 0", kp.key_valid); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL rdeb_held: got %b expected 0", kp.key_held); end
    reset = 1'b0;
    base = vcount;
    step(49);
    checks += 2;
    if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL rdeb_early_valid: got %b expected 0", kp.key_valid); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL rdeb_early_held: got %b expected 0", kp.key_held); end
    step(1);
    checks += 3;
    if (kp.key_valid !== 1'b1) begin failures++; $display("FAIL rdeb_accept_valid: got %b expected 1", kp.key_valid); end
    if (kp.key_code !== 4'h5) begin failures++; $display("FAIL rdeb_accept_code: got %h expected 5", kp.key_code); end
    if (kp.key_held !== 1'b1) begin failures++; $display("FAIL rdeb_accept_held: got %b expected 1", kp.key_held); end
    step(1);
    checks += 2;
    if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL rdeb_pulse_width: got %b expected 0", kp.key_valid); end
    if (vcount !== base + 1) begin failures++; $display("FAIL rdeb_count: got %0d expected 1", vcount - base); end
    step(20);
    reset = 1'b1;
    step(1);
    checks += 4;
    if (kp.key_row !== 4'b1110) begin failures++; $display("FAIL rheld_row: got %b expected 1110", kp.key_row); end
    if (kp.key_code !== 4'h0) begin failures++; $display("FAIL rheld_code: got %h expected 0", kp.key_code); end
    if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL rheld_valid: got %b expected 0", kp.key_valid); end
    if (kp.key_held !== 1'b0) begin failures++; $display("FAIL rheld_held: got %b expected 0", kp.key_held); end
    pressed = '0;
    reset = 1'b0;
    step(5);
  endtask

  initial begin
    reset = 1'b1;
    pressed = '0;
    test_reset();
    test_press_release();
    test_bounce();
    test_two_keys();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
